// File: rtl/cpu_run_pkg.sv
// Shared types and helpers for the CPU run controller: FSM state encoding and
// the one-bit rotate used by the optional register-file signature.
package cpu_run_pkg;

    localparam int SIG_MAX_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_RUN   = 3'd2,
        ST_DUMP  = 3'd3,
        ST_DONE  = 3'd4
    } run_state_t;

    // Rotate left by one within the low w bits; bits at and above w are zeroed.
    function automatic logic [SIG_MAX_W-1:0] rotl1(input logic [SIG_MAX_W-1:0] v, input int w);
        logic [SIG_MAX_W-1:0] mask;
        if (w >= SIG_MAX_W) begin
            mask = {SIG_MAX_W{1'b1}};
        end else begin
            mask = (64'd1 << w) - 64'd1;
        end
        return ((v << 1) | ((v >> (w - 1)) & 64'd1)) & mask;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Register-dump stream between the run controller (master) and its sink (slave).
interface cpu_run_ctrl_if #(
    parameter int NREGS = 32,
    parameter int WIDTH = 32
);
    localparam int ADDRW = $clog2(NREGS);

    logic             dump_valid;
    logic             dump_ready;
    logic [ADDRW-1:0] dump_idx;
    logic [WIDTH-1:0] dump_data;

    modport master (output dump_valid, output dump_idx, output dump_data, input dump_ready);
    modport slave  (input dump_valid, input dump_idx, input dump_data, output dump_ready);

endinterface

// File: rtl/run_cycle_counter.sv
// Saturating counter with synchronous load; used for both the CPU reset hold
// and the run-cycle budget.
module run_cycle_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Load wins over increment; counting stops at max_val rather than wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= W'(0);
        end else if (load) begin
            count_r <= load_val;
        end else if (inc && (count_r != max_val)) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: reset sequencing, bounded run, register-file dump.
// Optional signature check enabled by defining CPU_RUN_CTRL_SIGNATURE_EN.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter  int NREGS        = 32,
    parameter  int WIDTH        = 32,
    parameter  int RESET_CYCLES = 2,
    parameter  int MAX_CYCLES   = 100,
    localparam int ADDRW        = $clog2(NREGS),
    localparam int RUNW         = $clog2(MAX_CYCLES + 1),
    localparam int RSTW         = $clog2(RESET_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             halt,
    output logic             cpu_reset,
    output logic [ADDRW-1:0] rf_raddr,
    input  logic [WIDTH-1:0] rf_rdata,
    cpu_run_ctrl_if.master   dp,
    input  logic [WIDTH-1:0] expected_sig,
    output logic [RUNW-1:0]  run_cycles,
    output logic             done,
    output logic             timeout,
    output logic             pass
);

    run_state_t       state_r, state_nxt_s;
    logic [RSTW-1:0]  rst_cnt_s;
    logic [ADDRW-1:0] dump_idx_r;
    logic             cpu_reset_r, dump_valid_r, done_r, timeout_r, pass_r;
    logic             cpu_reset_nxt_s, dump_valid_nxt_s, done_nxt_s;
    logic             enter_reset_s, set_timeout_s, rst_inc_s, run_inc_s;
    logic             beat_s, last_beat_s, rst_done_s, run_limit_s, pass_nxt_s;

    assign beat_s      = dump_valid_r && dp.dump_ready;
    assign last_beat_s = beat_s && (dump_idx_r == ADDRW'(NREGS - 1));
    assign rst_done_s  = (rst_cnt_s == RSTW'(RESET_CYCLES - 1));
    assign run_limit_s = (run_cycles == RUNW'(MAX_CYCLES - 1));

    run_cycle_counter #(.W(RSTW)) u_rst_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (enter_reset_s),
        .load_val (RSTW'(0)),
        .inc      (rst_inc_s),
        .max_val  (RSTW'(RESET_CYCLES - 1)),
        .count    (rst_cnt_s)
    );

    run_cycle_counter #(.W(RUNW)) u_run_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (enter_reset_s),
        .load_val (RUNW'(0)),
        .inc      (run_inc_s),
        .max_val  (RUNW'(MAX_CYCLES)),
        .count    (run_cycles)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; halt is checked before the budget so it wins a tie.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  if (start) state_nxt_s = ST_RESET; else state_nxt_s = ST_IDLE;
            ST_RESET: if (rst_done_s) state_nxt_s = ST_RUN; else state_nxt_s = ST_RESET;
            ST_RUN:   if (halt || run_limit_s) state_nxt_s = ST_DUMP; else state_nxt_s = ST_RUN;
            ST_DUMP:  if (last_beat_s) state_nxt_s = ST_DONE; else state_nxt_s = ST_DUMP;
            ST_DONE:  if (start) state_nxt_s = ST_RESET; else state_nxt_s = ST_DONE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with state_r.
    always_comb begin
        enter_reset_s    = (state_nxt_s == ST_RESET) && (state_r != ST_RESET);
        cpu_reset_nxt_s  = (state_nxt_s != ST_RUN);
        dump_valid_nxt_s = (state_nxt_s == ST_DUMP);
        done_nxt_s       = (state_nxt_s == ST_DONE);
        set_timeout_s    = (state_r == ST_RUN) && !halt && run_limit_s;
        rst_inc_s        = (state_r == ST_RESET);
        run_inc_s        = (state_r == ST_RUN);
    end

    // Registered outputs and per-run status, all cleared when a new run begins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_reset_r  <= 1'b1;
            dump_valid_r <= 1'b0;
            done_r       <= 1'b0;
            timeout_r    <= 1'b0;
            pass_r       <= 1'b0;
            dump_idx_r   <= ADDRW'(0);
        end else begin
            cpu_reset_r  <= cpu_reset_nxt_s;
            dump_valid_r <= dump_valid_nxt_s;
            done_r       <= done_nxt_s;
            if (enter_reset_s) begin
                timeout_r  <= 1'b0;
                pass_r     <= 1'b0;
                dump_idx_r <= ADDRW'(0);
            end else begin
                if (set_timeout_s) timeout_r <= 1'b1; else timeout_r <= timeout_r;
                if (last_beat_s) pass_r <= pass_nxt_s; else pass_r <= pass_r;
                if (beat_s && !last_beat_s) dump_idx_r <= dump_idx_r + ADDRW'(1);
                else dump_idx_r <= dump_idx_r;
            end
        end
    end

`ifdef CPU_RUN_CTRL_SIGNATURE_EN
    logic [WIDTH-1:0] sig_r, sig_upd_s;

    assign sig_upd_s  = WIDTH'(rotl1(SIG_MAX_W'(sig_r), WIDTH)) ^ rf_rdata;
    assign pass_nxt_s = !timeout_r && (sig_upd_s == expected_sig);

    // Signature accumulates every accepted beat; the final beat is folded into pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_r <= {WIDTH{1'b0}};
        end else if (enter_reset_s) begin
            sig_r <= {WIDTH{1'b0}};
        end else if (beat_s) begin
            sig_r <= sig_upd_s;
        end else begin
            sig_r <= sig_r;
        end
    end
`else
    logic unused_expected_sig_s;

    assign unused_expected_sig_s = ^expected_sig;
    assign pass_nxt_s            = !timeout_r;
`endif

    assign cpu_reset     = cpu_reset_r;
    assign rf_raddr      = dump_idx_r;
    assign dp.dump_valid = dump_valid_r;
    assign dp.dump_idx   = dump_idx_r;
    assign dp.dump_data  = rf_rdata;
    assign done          = done_r;
    assign timeout       = timeout_r;
    assign pass          = pass_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl (NREGS=32, RESET_CYCLES=2, MAX_CYCLES=100).
module tb_cpu_run_ctrl;

    localparam int NREGS = 32;
    localparam int WIDTH = 32;
    localparam int RC    = 2;
    localparam int MAXC  = 100;

    logic        clk = 1'b0;
    logic        reset_n, start, halt, cpu_reset, done, timeout, pass;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata, expected_sig;
    logic [6:0]  run_cycles;
    logic [31:0] rf [NREGS];
    bit          pat [4];
    int          n_chk = 0;
    int          n_err = 0;

    cpu_run_ctrl_if #(.NREGS(NREGS), .WIDTH(WIDTH)) dif ();

    cpu_run_ctrl #(.NREGS(NREGS), .WIDTH(WIDTH), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .halt         (halt),
        .cpu_reset    (cpu_reset),
        .rf_raddr     (rf_raddr),
        .rf_rdata     (rf_rdata),
        .dp           (dif.master),
        .expected_sig (expected_sig),
        .run_cycles   (run_cycles),
        .done         (done),
        .timeout      (timeout),
        .pass         (pass)
    );

    assign rf_rdata = rf[rf_raddr];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] tb_sig();
        logic [31:0] s;
        s = 32'h0;
        for (int i = 0; i < NREGS; i++) s = {s[30:0], s[31]} ^ rf[i];
        return s;
    endfunction

    // start pulse on edge N; cpu_reset must still be high after N+1 and low after N+2
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("rst_hold", 64'(cpu_reset), 64'(1));
        tick();
        chk("rst_release", 64'(cpu_reset), 64'(0));
        chk("run_start", 64'(run_cycles), 64'(0));
    endtask

    task automatic run_phase(input int halt_at, output int low_edges);
        int k;
        k = 0;
        low_edges = 0;
        while (cpu_reset == 1'b0 && k < 300) begin
            halt  = (k == halt_at);
            start = (k == 20);
            tick();
            low_edges++;
            k++;
        end
        halt  = 1'b0;
        start = 1'b0;
    endtask

    task automatic dump_phase(input bit toggle, output int beats, output int bad, output int cycles);
        int          exp_idx;
        bit          rdy, prev_rdy;
        logic [31:0] prev_data;
        beats = 0; bad = 0; cycles = 0; exp_idx = 0; prev_rdy = 1'b1; prev_data = 32'h0;
        while (dif.dump_valid == 1'b1 && cycles < 300) begin
            if (dif.dump_idx !== 5'(exp_idx) || dif.dump_data !== rf[exp_idx[4:0]]) bad++;
            if (!prev_rdy && dif.dump_data !== prev_data) bad++;
            rdy            = toggle ? pat[cycles % 4] : 1'b1;
            dif.dump_ready = rdy;
            start          = (cycles == 1);
            prev_rdy       = rdy;
            prev_data      = dif.dump_data;
            tick();
            cycles++;
            if (rdy) begin
                beats++;
                exp_idx++;
            end
        end
        dif.dump_ready = 1'b0;
        start          = 1'b0;
    endtask

    task automatic full_run(input int halt_at, input bit toggle, input int exp_edges,
                            input int exp_rc, input bit exp_to, input bit exp_pass);
        int le, beats, bad, cyc;
        pulse_start();
        run_phase(halt_at, le);
        chk("run_edges", 64'(le), 64'(exp_edges));
        chk("dump_valid_start", 64'(dif.dump_valid), 64'(1));
        chk("run_cycles", 64'(run_cycles), 64'(exp_rc));
        chk("timeout_dump", 64'(timeout), 64'(exp_to));
        dump_phase(toggle, beats, bad, cyc);
        chk("beats", 64'(beats), 64'(NREGS));
        chk("dump_order", 64'(bad), 64'(0));
        if (!toggle) chk("dump_len", 64'(cyc), 64'(NREGS));
        chk("done", 64'(done), 64'(1));
        chk("dump_valid_done", 64'(dif.dump_valid), 64'(0));
        chk("timeout_done", 64'(timeout), 64'(exp_to));
        chk("pass", 64'(pass), 64'(exp_pass));
    endtask

    initial begin
        int g, le;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int i = 0; i < NREGS; i++) rf[i] = 32'h1234_5678 ^ (32'(i) * 32'h0101_0101);
        reset_n = 1'b0; start = 1'b0; halt = 1'b0; dif.dump_ready = 1'b0; expected_sig = 32'h0;
        repeat (3) tick();
        chk("rst_cpu_reset", 64'(cpu_reset), 64'(1));
        chk("rst_dump_valid", 64'(dif.dump_valid), 64'(0));
        chk("rst_dump_idx", 64'(dif.dump_idx), 64'(0));
        chk("rst_raddr", 64'(rf_raddr), 64'(0));
        chk("rst_data", 64'(dif.dump_data), 64'(rf[0]));
        chk("rst_run_cycles", 64'(run_cycles), 64'(0));
        chk("rst_flags", 64'({done, timeout, pass}), 64'(0));
        reset_n = 1'b1;
        repeat (5) tick();
        chk("idle_cpu_reset", 64'(cpu_reset), 64'(1));

        // halt at RUN cycle 40, then DONE holds its status
        full_run(40, 1'b0, 41, 41, 1'b0, 1'b1);
        repeat (3) tick();
        chk("done_hold", 64'({done, pass, timeout}), 64'(3'b110));

        // restart from DONE: no halt, halt on the last budget cycle, stalled sink
        full_run(-1, 1'b0, MAXC, MAXC, 1'b1, 1'b0);
        full_run(MAXC - 1, 1'b0, MAXC, MAXC, 1'b0, 1'b1);
        full_run(10, 1'b1, 11, 11, 1'b0, 1'b1);

        // reset_n pulsed low mid-dump at index 7
        pulse_start();
        run_phase(3, le);
        dif.dump_ready = 1'b1;
        g = 0;
        while (dif.dump_idx != 5'd7 && g < 100) begin
            tick();
            g++;
        end
        chk("reach_idx7", 64'(dif.dump_idx), 64'(7));
        reset_n = 1'b0;
        #1;
        chk("abort_valid", 64'(dif.dump_valid), 64'(0));
        chk("abort_cpu_reset", 64'(cpu_reset), 64'(1));
        chk("abort_idx", 64'(dif.dump_idx), 64'(0));
        chk("abort_run_cycles", 64'(run_cycles), 64'(0));
        dif.dump_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("abort_idle", 64'({cpu_reset, dif.dump_valid, done}), 64'(3'b100));
        full_run(5, 1'b0, 6, 6, 1'b0, 1'b1);

        for (int i = 0; i < NREGS; i++) rf[i] = 32'(i);
`ifdef CPU_RUN_CTRL_SIGNATURE_EN
        expected_sig = tb_sig();
        full_run(7, 1'b0, 8, 8, 1'b0, 1'b1);
        expected_sig = tb_sig() ^ 32'h0000_0001;
        full_run(7, 1'b0, 8, 8, 1'b0, 1'b0);
`else
        expected_sig = tb_sig() ^ 32'hDEAD_BEEF;
        full_run(7, 1'b0, 8, 8, 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable run controller for CPU simulation and FPGA bring-up. Sequences the CPU reset, runs the core for a bounded number of cycles or until it signals halt, then freezes the core and streams every register-file entry out over a valid/ready port. It sits between the top-level harness and the `CPU` instance, replacing fixed-delay reset/run/dump scripting with a parametrised, cycle-exact controller.

## Interface
- `NREGS`, 32, number of register-file entries to dump (≥2)
- `WIDTH`, 32, register data width
- `RESET_CYCLES`, 2, cycles `cpu_reset` is held after `start` (≥1)
- `MAX_CYCLES`, 100, run budget in cycles before timeout (≥1)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; honoured only in IDLE or DONE
- `halt`  in  1  CPU end-of-program indication; sampled in RUN only
- `cpu_reset`  out  1  active-high reset to the CPU
- `rf_raddr`  out  $clog2(NREGS)  register-file read address
- `rf_rdata`  in  WIDTH  combinational read data for `rf_raddr`
- `dump_valid`  out  1  dump beat valid
- `dump_ready`  in  1  sink accepts beat
- `dump_idx`  out  $clog2(NREGS)  register index of current beat
- `dump_data`  out  WIDTH  register value of current beat
- `expected_sig`  in  WIDTH  golden signature (used only with signature feature)
- `run_cycles`  out  $clog2(MAX_CYCLES+1)  cycles spent in RUN
- `done`  out  1  run and dump complete
- `timeout`  out  1  budget exhausted without halt
- `pass`  out  1  valid when `done`=1

## Operation
- States: IDLE, RESET, RUN, DUMP, DONE.
- IDLE: `cpu_reset`=1; `start` → RESET.
- RESET: `cpu_reset`=1; counter runs 0..RESET_CYCLES-1, then → RUN. On entry: `run_cycles`, `timeout`, `pass`, signature and dump index cleared.
- RUN: `cpu_reset`=0; `run_cycles` increments each cycle. `halt`=1 → DUMP with `timeout`=0. `run_cycles`==MAX_CYCLES-1 with no halt → DUMP with `timeout`=1. Both in the same cycle: halt wins, `timeout`=0.
- DUMP: `cpu_reset`=1 (core frozen); `rf_raddr`=`dump_idx`, `dump_data`=`rf_rdata`, `dump_valid`=1. On `dump_valid && dump_ready`, index increments; acceptance of index NREGS-1 → DONE. `dump_ready` low stalls indefinitely, holding index and data.
- DONE: `cpu_reset`=1, `done`=1, `dump_valid`=0; `pass` and `timeout` held. `start` → RESET (restart).
- `start` in RESET/RUN/DUMP is ignored.
- `run_cycles` saturates at MAX_CYCLES and never wraps.

## Timing
- Reset values: `cpu_reset`=1, `dump_valid`=0, `dump_idx`=0, `rf_raddr`=0, `dump_data`=`rf_rdata` (combinational), `run_cycles`=0, `done`=0, `timeout`=0, `pass`=0; state IDLE.
- `reset_n` low at any time, including mid-RUN or mid-DUMP: immediate return to IDLE, in-flight dump abandoned.
- `start` at edge N → `cpu_reset` deasserts for edge N+1+RESET_CYCLES; CPU runs exactly `run_cycles` edges.
- `halt` seen at edge M → `dump_valid` high from M+1; minimum dump duration NREGS cycles with `dump_ready` held high.
- `done` rises the cycle after the final beat handshake; `pass` is valid in the same cycle.
- All outputs registered except `dump_data` and `rf_raddr` decode.

## Configuration
- `CPU_RUN_CTRL_SIGNATURE_EN` defined: each accepted beat updates `sig = rotl1(sig) ^ dump_data` (initial value 0); in DONE, `pass` = !`timeout` && (`sig` == `expected_sig`).
- Undefined: no signature logic; `pass` = !`timeout`; `expected_sig` stays on the port and is ignored.

## Structure
- Shared package `cpu_run_pkg`: state enum `run_state_t`, `rotl1` signature function.
- Sub-module `run_cycle_counter`: saturating, loadable counter reused for the RESET and RUN phases.

## Test plan
- NREGS=32, RESET_CYCLES=2, MAX_CYCLES=100; `start` at cycle 5, `halt` at RUN cycle 40 → `cpu_reset` low for exactly 41 edges, `run_cycles`=41, 32 beats with indices 0..31, `timeout`=0, `pass`=1.
- No halt → `run_cycles`=100, `timeout`=1, dump still completes, `pass`=0.
- `halt` coincident with RUN cycle 99 → `timeout`=0, `pass`=1.
- `dump_ready` toggling 1,0,0,1 → no duplicated or skipped index; `dump_data` stable while stalled.
- `reset_n` pulsed low at dump index 7 → IDLE, `dump_valid`=0; new `start` produces a full dump from index 0.
- With `CPU_RUN_CTRL_SIGNATURE_EN` defined: registers loaded with 0..31 and `expected_sig` set to the matching signature → `pass`=1; `expected_sig` off by one bit → `pass`=0.
